// File: rtl/mask_sched_pkg.sv
// Shared types and defaults for the mask-calculator column scheduler.
// Registered datapath, 1-cycle output latency; flow is paced by i_ready.
package mask_sched_pkg;

  localparam int NUM_COLS_DEF  = 4;
  localparam int BUS_WIDTH_DEF = 16;
  localparam int TMO_CYC_DEF   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [BUS_WIDTH_DEF-1:0] offset;
    logic [4:0]               width;
  } desc_t;

endpackage

// File: rtl/mask_desc_table.sv
// Column-descriptor register file: one synchronous write port, one combinational read port.
// Write lands on the next edge; read and nonzero-width flags are same-cycle, no backpressure.
module mask_desc_table
  import mask_sched_pkg::*;
#(
  parameter int NUM_COLS = NUM_COLS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [1:0]          waddr,
  input  desc_t               wdata,
  input  logic [1:0]          raddr,
  output desc_t               rdata,
  output logic [NUM_COLS-1:0] width_nz
);

  desc_t slot [NUM_COLS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_COLS; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_COLS; i++) begin
        if (we && (waddr == 2'(i))) slot[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (raddr == 2'(i)) rdata = slot[i];
      width_nz[i] = |slot[i].width;
    end
  end

endmodule

// File: rtl/mask_sched.sv
// Steps a mask calculator through up to NUM_COLS column descriptors per job.
// All outputs registered (1 cycle after the deciding edge); i_ready gates timeout and row counting.
module mask_sched
  import mask_sched_pkg::*;
#(
  parameter int NUM_COLS  = NUM_COLS_DEF,
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int TMO_CYC   = TMO_CYC_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cfg_we,
  input  logic [1:0]           i_cfg_idx,
  input  logic [BUS_WIDTH-1:0] i_cfg_offset,
  input  logic [4:0]           i_cfg_width,
  input  logic [2:0]           i_col_count,
  input  logic [BUS_WIDTH-1:0] i_row_size,
  input  logic [BUS_WIDTH-1:0] i_row_cnt,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_ready,
  input  logic                 i_mc_active,
  output logic                 o_mc_en,
  output logic [BUS_WIDTH-1:0] o_mc_offset,
  output logic [4:0]           o_mc_col_width,
  output logic [BUS_WIDTH-1:0] o_mc_row_cnt,
  output logic [BUS_WIDTH-1:0] o_mc_row_size,
  output logic [1:0]           o_col_idx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [BUS_WIDTH+2:0] o_rows_issued
);

  localparam int TMO_W = $clog2(TMO_CYC + 1);
  localparam int RI_W  = BUS_WIDTH + 3;

  state_t               state_q, state_d;
  logic [TMO_W-1:0]     tmo_q;
  logic [2:0]           col_count_q;
  desc_t                wr_desc, rd_desc;
  logic [NUM_COLS-1:0]  width_nz;
  logic [1:0]           rd_idx;
  logic                 busy, start_ok, tmo_hit, err_d;

  assign busy           = (state_q != ST_IDLE);
  assign wr_desc.offset = BUS_WIDTH_DEF'(i_cfg_offset);
  assign wr_desc.width  = i_cfg_width;
  // The only LOAD entries are from IDLE (slot 0) and from GAP (next slot).
  assign rd_idx         = (state_q == ST_GAP) ? (o_col_idx + 2'd1) : 2'd0;
  assign tmo_hit        = (state_q == ST_LOAD) && i_ready && !i_mc_active &&
                          (tmo_q == TMO_W'(TMO_CYC - 1));

  mask_desc_table #(.NUM_COLS(NUM_COLS)) u_desc (
    .clk      (i_clk),
    .rst      (i_rst),
    .we       (i_cfg_we && !busy),
    .waddr    (i_cfg_idx),
    .wdata    (wr_desc),
    .raddr    (rd_idx),
    .rdata    (rd_desc),
    .width_nz (width_nz)
  );

  always_comb begin
    start_ok = (i_col_count != 3'd0) && (int'(i_col_count) <= NUM_COLS) && (i_row_cnt != '0);
    for (int i = 0; i < NUM_COLS; i++) begin
      if ((i < int'(i_col_count)) && !width_nz[i]) start_ok = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          if (start_ok) state_d = ST_LOAD;
          else          err_d   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (i_mc_active) begin
          state_d = ST_RUN;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_RUN:  if (!i_mc_active) state_d = ST_GAP;
      ST_GAP:  state_d = (({1'b0, o_col_idx} + 3'd1) < col_count_q) ? ST_LOAD : ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (busy && i_abort) begin
      state_d = ST_IDLE;
      err_d   = (state_q != ST_DONE);
    end
    if (busy && i_cfg_we) err_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= ST_IDLE;
      tmo_q          <= '0;
      col_count_q    <= '0;
      o_mc_en        <= 1'b0;
      o_mc_offset    <= '0;
      o_mc_col_width <= '0;
      o_mc_row_cnt   <= '0;
      o_mc_row_size  <= '0;
      o_col_idx      <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_err          <= 1'b0;
      o_rows_issued  <= '0;
    end else begin
      state_q <= state_d;
      o_err   <= err_d;
      o_busy  <= (state_d != ST_IDLE);
      o_done  <= (state_d == ST_DONE);
      o_mc_en <= (state_d == ST_LOAD) || (state_d == ST_RUN);

      if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
        tmo_q          <= '0;
        o_col_idx      <= rd_idx;
        o_mc_offset    <= BUS_WIDTH'(rd_desc.offset);
        o_mc_col_width <= rd_desc.width;
      end else if ((state_q == ST_LOAD) && i_ready && !i_mc_active) begin
        tmo_q <= tmo_q + TMO_W'(1);
      end

      if ((state_q == ST_IDLE) && (state_d == ST_LOAD)) begin
        col_count_q   <= i_col_count;
        o_mc_row_cnt  <= i_row_cnt;
        o_mc_row_size <= i_row_size;
        o_rows_issued <= '0;
      end else if (busy && i_ready && i_mc_active && (o_rows_issued != {RI_W{1'b1}})) begin
        o_rows_issued <= o_rows_issued + RI_W'(1);
      end

      if (state_d == ST_IDLE) begin
        o_col_idx      <= '0;
        o_mc_offset    <= '0;
        o_mc_col_width <= '0;
        o_mc_row_cnt   <= '0;
        o_mc_row_size  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mask_sched.sv
// Directed bench for mask_sched with a small mask-calculator model driven at the falling edge.
module tb_mask_sched;
  import mask_sched_pkg::*;

  localparam int BW = 16;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_cfg_we;
  logic [1:0]    i_cfg_idx;
  logic [BW-1:0] i_cfg_offset;
  logic [4:0]    i_cfg_width;
  logic [2:0]    i_col_count;
  logic [BW-1:0] i_row_size, i_row_cnt;
  logic          i_start, i_abort, i_ready, i_mc_active;
  logic          o_mc_en;
  logic [BW-1:0] o_mc_offset;
  logic [4:0]    o_mc_col_width;
  logic [BW-1:0] o_mc_row_cnt, o_mc_row_size;
  logic [1:0]    o_col_idx;
  logic          o_busy, o_done, o_err;
  logic [BW+2:0] o_rows_issued;

  mask_sched dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cfg_we(i_cfg_we), .i_cfg_idx(i_cfg_idx),
    .i_cfg_offset(i_cfg_offset), .i_cfg_width(i_cfg_width), .i_col_count(i_col_count),
    .i_row_size(i_row_size), .i_row_cnt(i_row_cnt), .i_start(i_start), .i_abort(i_abort),
    .i_ready(i_ready), .i_mc_active(i_mc_active), .o_mc_en(o_mc_en), .o_mc_offset(o_mc_offset),
    .o_mc_col_width(o_mc_col_width), .o_mc_row_cnt(o_mc_row_cnt), .o_mc_row_size(o_mc_row_size),
    .o_col_idx(o_col_idx), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_rows_issued(o_rows_issued)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // calculator model state
  bit calc_on, calc_started, calc_fin;
  int calc_rows, calc_left;

  // job observation results
  int offs [4];
  int n_offs, done_n, err_n, gap_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; the model sees the outputs of the edge just taken and pulses are cleared.
  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
    if (!o_mc_en) begin
      calc_started = 0;
      calc_fin     = 0;
      i_mc_active  = 1'b0;
    end else if (calc_on && !calc_fin) begin
      if (!calc_started) begin
        calc_started = 1;
        calc_left    = calc_rows;
        i_mc_active  = 1'b1;
      end else if (i_mc_active && i_ready) begin
        calc_left--;
        if (calc_left == 0) begin
          i_mc_active = 1'b0;
          calc_fin    = 1;
        end
      end
    end
    i_start  = 1'b0;
    i_abort  = 1'b0;
    i_cfg_we = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [BW-1:0] off, input logic [4:0] w);
    i_cfg_we     = 1'b1;
    i_cfg_idx    = idx;
    i_cfg_offset = off;
    i_cfg_width  = w;
    tick();
  endtask

  task automatic start_job(input logic [2:0] cc, input logic [BW-1:0] rc, input logic [BW-1:0] rs);
    i_col_count = cc;
    i_row_cnt   = rc;
    i_row_size  = rs;
    calc_rows   = int'(rc);
    i_start     = 1'b1;
    tick();
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit prev_en = 0;
    n_offs = 0; done_n = 0; err_n = 0; gap_n = 0;
    for (int k = 0; k < budget && o_busy; k++) begin
      if (o_mc_en && !prev_en && n_offs < 4) begin
        offs[n_offs] = int'(o_mc_offset);
        n_offs++;
      end
      if (!o_mc_en && !o_done) gap_n++;
      if (o_done) done_n++;
      if (o_err) err_n++;
      prev_en = o_mc_en;
      tick();
    end
    if (o_err) err_n++;
    chk({tag, "_ended"}, o_busy, 0);
  endtask

  initial begin
    bit found, quiet;

    i_rst = 1'b1; i_cfg_we = 0; i_cfg_idx = 0; i_cfg_offset = 0; i_cfg_width = 0;
    i_col_count = 0; i_row_size = 0; i_row_cnt = 0; i_start = 0; i_abort = 0;
    i_ready = 1'b1; i_mc_active = 0; calc_on = 1; calc_rows = 0;

    // reset state
    repeat (2) @(negedge i_clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_en", o_mc_en, 0);
    chk("rst_err", o_err, 0);
    chk("rst_done", o_done, 0);
    chk("rst_rows", o_rows_issued, 0);
    chk("rst_offset", o_mc_offset, 0);
    i_rst = 1'b0;
    tick();

    // two-column job, 3 rows each
    cfg_write(2'd0, 16'h0004, 5'd8);
    cfg_write(2'd1, 16'h0020, 5'd4);
    start_job(3'd2, 16'd3, 16'h0040);
    chk("j1_busy", o_busy, 1);
    chk("j1_en", o_mc_en, 1);
    chk("j1_col_idx", o_col_idx, 0);
    chk("j1_width", o_mc_col_width, 8);
    chk("j1_row_cnt", o_mc_row_cnt, 3);
    chk("j1_row_size", o_mc_row_size, 16'h0040);
    wait_done("j1", 100);
    chk("j1_n_cols", n_offs, 2);
    chk("j1_off0", offs[0], 32'h4);
    chk("j1_off1", offs[1], 32'h20);
    chk("j1_gaps", gap_n, 2);
    chk("j1_done", done_n, 1);
    chk("j1_err", err_n, 0);
    chk("j1_rows", o_rows_issued, 6);
    chk("j1_idle_offset", o_mc_offset, 0);

    // stall inside RUN, plus a descriptor write while busy
    start_job(3'd1, 16'd4, 16'h0010);
    tick();
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        i_cfg_we = 1'b1; i_cfg_idx = 2'd0; i_cfg_offset = 16'h7777; i_cfg_width = 5'd0;
      end
      tick();
      if (k == 2) chk("busy_cfg_err", o_err, 1);
      chk("stall_en", o_mc_en, 1);
    end
    chk("stall_rows", o_rows_issued, 1);
    chk("stall_busy", o_busy, 1);
    i_ready = 1'b1;
    wait_done("j2", 100);
    chk("j2_done", done_n, 1);
    chk("j2_rows", o_rows_issued, 4);

    // illegal starts
    start_job(3'd0, 16'd3, 16'h0);
    chk("cc0_err", o_err, 1);
    chk("cc0_busy", o_busy, 0);
    tick();
    chk("cc0_err_pulse", o_err, 0);
    start_job(3'd3, 16'd3, 16'h0);
    chk("w0_err", o_err, 1);
    chk("w0_busy", o_busy, 0);
    start_job(3'd5, 16'd3, 16'h0);
    chk("cc5_err", o_err, 1);
    start_job(3'd1, 16'd0, 16'h0);
    chk("rc0_err", o_err, 1);
    i_abort = 1'b1;
    start_job(3'd1, 16'd3, 16'h0);
    chk("abort_start_busy", o_busy, 0);
    chk("abort_start_err", o_err, 0);

    // calculator never goes active: timeout
    calc_on = 0;
    start_job(3'd1, 16'd3, 16'h0);
    chk("tmo_width_kept", o_mc_col_width, 8);
    quiet = 1;
    for (int k = 1; k < 16; k++) begin
      tick();
      if (o_err || !o_mc_en) quiet = 0;
    end
    chk("tmo_quiet_15", quiet, 1);
    tick();
    chk("tmo_err", o_err, 1);
    chk("tmo_busy", o_busy, 0);
    chk("tmo_en", o_mc_en, 0);
    tick();
    chk("tmo_err_pulse", o_err, 0);
    calc_on = 1;

    // abort in column 1 RUN, then a clean job
    start_job(3'd2, 16'd3, 16'h0);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick();
      if (o_col_idx == 2'd1 && o_mc_en) found = 1;
    end
    chk("ab_reach_col1", found, 1);
    tick();
    chk("ab_run_en", o_mc_en, 1);
    i_abort = 1'b1;
    tick();
    chk("ab_en", o_mc_en, 0);
    chk("ab_err", o_err, 1);
    chk("ab_busy", o_busy, 0);
    chk("ab_done", o_done, 0);
    start_job(3'd2, 16'd3, 16'h0);
    wait_done("j3", 100);
    chk("j3_done", done_n, 1);
    chk("j3_err", err_n, 0);
    chk("j3_rows", o_rows_issued, 6);

    // asynchronous reset mid-RUN
    start_job(3'd2, 16'd3, 16'h0);
    tick();
    chk("rr_run_en", o_mc_en, 1);
    #2 i_rst = 1'b1;
    #1;
    chk("rr_en", o_mc_en, 0);
    chk("rr_busy", o_busy, 0);
    chk("rr_offset", o_mc_offset, 0);
    chk("rr_rows", o_rows_issued, 0);
    chk("rr_err", o_err, 0);
    chk("rr_done", o_done, 0);
    tick();
    i_rst = 1'b0;
    tick();
    start_job(3'd1, 16'd1, 16'h0);
    chk("rr_slot_cleared_err", o_err, 1);
    chk("rr_slot_cleared_busy", o_busy, 0);
    cfg_write(2'd0, 16'h0010, 5'd2);
    start_job(3'd1, 16'd2, 16'h0);
    chk("j4_en", o_mc_en, 1);
    chk("j4_offset", o_mc_offset, 16'h0010);
    wait_done("j4", 100);
    chk("j4_done", done_n, 1);
    chk("j4_err", err_n, 0);
    chk("j4_rows", o_rows_issued, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
